// File: rtl/wb_burst_mem_slave.sv
// Wishbone B3 slave memory with registered-feedback classic/const/incr/wrap bursts.
// Define WB_MEM_WAIT_EN to insert LFSR-driven wait states.
module wb_burst_mem_slave #(
   parameter int unsigned aw        = 32,
   parameter int unsigned dw        = 32,
   parameter int unsigned MEM_WORDS = 1024,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic [aw-1:0]     wb_adr_i,
   input  logic [dw-1:0]     wb_dat_i,
   input  logic [dw/8-1:0]   wb_sel_i,
   input  logic              wb_we_i,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic [2:0]        wb_cti_i,
   input  logic [1:0]        wb_bte_i,
   output logic [dw-1:0]     wb_dat_o,
   output logic              wb_ack_o,
   output logic              wb_err_o,
   output logic              wb_rty_o
);

   localparam int unsigned SEL_W  = dw / 8;
   localparam int unsigned AW_LSB = $clog2(SEL_W);
   localparam int unsigned IDX_W  = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_CLASSIC, S_BURST} state_e;

   state_e            state_q, state_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic [dw-1:0]     dat_q, dat_d;
   logic [aw-1:0]     pred_q, pred_d;
   logic [dw-1:0]     mem [MEM_WORDS];

   logic              req_c;
   logic              oor_c;
   logic              hold_c;
   logic              burst_cti_c;
   logic              we_c;
   logic [IDX_W-1:0]  idx_c;
   logic [aw-1:0]     wrap_mask_c;
   logic [aw-1:0]     next_adr_c;

   assign req_c       = wb_cyc_i & wb_stb_i;
   assign idx_c       = wb_adr_i[AW_LSB +: IDX_W];
   assign oor_c       = (wb_adr_i >> (AW_LSB + IDX_W)) != '0;
   assign burst_cti_c = (wb_cti_i == 3'b001) || (wb_cti_i == 3'b010);

`ifdef WB_MEM_WAIT_EN
   logic [7:0] lfsr_q, lfsr_d;

   // Fibonacci LFSR, taps 8,6,5,4; bit 0 high withholds the response
   assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   assign hold_c = lfsr_q[0];

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) lfsr_q <= LFSR_SEED;
      else            lfsr_q <= lfsr_d;
   end
`else
   logic unused_seed_c;
   assign unused_seed_c = ^LFSR_SEED;
   assign hold_c        = 1'b0;
`endif

   // Address the master must present on the following beat
   always_comb begin
      wrap_mask_c = '0;
      unique case (wb_bte_i)
         2'b01:   wrap_mask_c = aw'(4 * SEL_W - 1);
         2'b10:   wrap_mask_c = aw'(8 * SEL_W - 1);
         2'b11:   wrap_mask_c = aw'(16 * SEL_W - 1);
         default: wrap_mask_c = '0;
      endcase
      if (wb_cti_i == 3'b001)
         next_adr_c = wb_adr_i;
      else if (wb_bte_i == 2'b00)
         next_adr_c = wb_adr_i + aw'(SEL_W);
      else
         next_adr_c = (wb_adr_i & ~wrap_mask_c) | ((wb_adr_i + aw'(SEL_W)) & wrap_mask_c);
   end

   always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      dat_d   = dat_q;
      pred_d  = pred_q;
      we_c    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_c && !hold_c) begin
               if (oor_c) begin
                  err_d   = 1'b1;
                  state_d = S_CLASSIC;
               end else begin
                  ack_d = 1'b1;
                  we_c  = wb_we_i;
                  if (!wb_we_i) dat_d = mem[idx_c];
                  if (burst_cti_c) begin
                     state_d = S_BURST;
                     pred_d  = next_adr_c;
                  end else begin
                     state_d = S_CLASSIC;
                  end
               end
            end
         end
         // Response cycle: the still-held strobe belongs to the acked transfer
         S_CLASSIC: state_d = S_IDLE;
         S_BURST: begin
            if (!wb_cyc_i) begin
               state_d = S_IDLE;
            end else if (wb_stb_i && !hold_c) begin
               if (wb_adr_i != pred_q) begin
                  state_d = S_IDLE;
               end else if (oor_c) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ack_d = 1'b1;
                  we_c  = wb_we_i;
                  if (!wb_we_i) dat_d = mem[idx_c];
                  if (burst_cti_c) pred_d  = next_adr_c;
                  else             state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= S_IDLE;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
         pred_q  <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
         pred_q  <= pred_d;
      end
   end

   // RAM has no reset so contents survive it; writes are blocked while reset is held
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_ni && we_c) begin
         for (int b = 0; b < SEL_W; b++) begin
            if (wb_sel_i[b]) mem[idx_c][8*b +: 8] <= wb_dat_i[8*b +: 8];
         end
      end
   end

   assign wb_dat_o = dat_q;
   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;
   assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_burst_mem_slave.sv
// Directed bench for wb_burst_mem_slave: transaction-level memory model with per-cycle
// expected ack/err/data tables, plus literal spot checks.
module tb_wb_burst_mem_slave;

   localparam int unsigned NW = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] adr, dat_i, dat_o;
   logic [3:0]  sel;
   logic        we, cyc, stb, ack, err, rty;
   logic [2:0]  cti;
   logic [1:0]  bte;

   wb_burst_mem_slave dut (
      .wb_clk_i (clk),   .wb_rst_ni(rst_n),
      .wb_adr_i (adr),   .wb_dat_i (dat_i), .wb_sel_i(sel),
      .wb_we_i  (we),    .wb_cyc_i (cyc),   .wb_stb_i(stb),
      .wb_cti_i (cti),   .wb_bte_i (bte),
      .wb_dat_o (dat_o), .wb_ack_o (ack),   .wb_err_o(err),
      .wb_rty_o (rty)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc_n   = 0;
   bit          chk_on  = 1'b0;
   bit          e_ack  [4096];
   bit          e_err  [4096];
   bit          e_dchk [4096];
   logic [31:0] e_dat  [4096];
   logic [31:0] mm     [NW];
   logic [31:0] last_dat = 32'h0;

   always @(posedge clk) cyc_n++;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
      end
   endtask

   // Expected next address from the burst rules: const holds, linear steps, wrap-N wraps in N beats
   function automatic logic [31:0] next_adr(input logic [31:0] a, input logic [2:0] c, input logic [1:0] b);
      int unsigned span;
      if (c == 3'b001) return a;
      if (b == 2'b00) return a + 32'd4;
      span = (32'd4 << (int'(b) - 1)) * 32'd4;
      return (a - (a % span)) + (((a % span) + 32'd4) % span);
   endfunction

   // One accepted beat: record what the slave must show on the following cycle
   task automatic model_beat(input logic [31:0] a, input logic w, input logic [31:0] d,
                             input logic [3:0] s, input int c);
      int unsigned idx;
      idx = a / 4;
      if (idx >= NW) begin
         e_err[c+1]  = 1'b1;
         e_dchk[c+1] = 1'b1;
         e_dat[c+1]  = last_dat;
      end else begin
         e_ack[c+1] = 1'b1;
         if (w) begin
            for (int b = 0; b < 4; b++) if (s[b]) mm[idx][8*b +: 8] = d[8*b +: 8];
         end else begin
            last_dat    = mm[idx];
            e_dchk[c+1] = 1'b1;
            e_dat[c+1]  = last_dat;
         end
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("ack", {31'b0, ack}, {31'b0, e_ack[cyc_n]});
         check("err", {31'b0, err}, {31'b0, e_err[cyc_n]});
         check("rty", {31'b0, rty}, 32'h0);
         if (e_dchk[cyc_n]) check("dat", dat_o, e_dat[cyc_n]);
      end
   end

   task automatic drive(input logic c, input logic s, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] sl, input logic [2:0] ct,
                        input logic [1:0] bt);
      @(posedge clk); #1;
      cyc = c; stb = s; we = w; adr = a; dat_i = d; sel = sl; cti = ct; bte = bt;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
   endtask

   // Classic cycle; strobe is held through the ack cycle as a registered-feedback master does
   task automatic classic(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
      drive(1'b1, 1'b1, w, a, d, s, 3'b000, 2'b00);
      model_beat(a, w, d, s, cyc_n);
      drive(1'b1, 1'b1, w, a, d, s, 3'b000, 2'b00);
   endtask

   // Pipelined burst; data for beat i is seed+i; optional one-cycle stb stall before beat stall_at
   task automatic burst(input logic [31:0] start, input int n, input logic w, input logic [2:0] ck,
                        input logic [1:0] bt, input logic [31:0] seed, input int stall_at);
      logic [31:0] a;
      a = start;
      for (int i = 0; i < n; i++) begin
         if (i == stall_at) drive(1'b1, 1'b0, w, a, 32'h0, 4'hF, ck, bt);
         drive(1'b1, 1'b1, w, a, seed + 32'(i), 4'hF, (i == n - 1) ? 3'b111 : ck, bt);
         model_beat(a, w, seed + 32'(i), 4'hF, cyc_n);
         a = next_adr(a, ck, bt);
      end
      idle(1);
   endtask

   initial begin
      rst_n = 1'b1;
      cyc = 0; stb = 0; we = 0; adr = 0; dat_i = 0; sel = 0; cti = 0; bte = 0;
      #1 rst_n = 1'b0;
      #2;
      check("rst_ack", {31'b0, ack}, 32'h0);
      check("rst_err", {31'b0, err}, 32'h0);
      check("rst_dat", dat_o, 32'h0);

      check("model_wrap4", next_adr(32'h20C, 3'b010, 2'b01), 32'h200);
      check("model_wrap8", next_adr(32'h11C, 3'b010, 2'b10), 32'h100);
      check("model_wrap16", next_adr(32'h23C, 3'b010, 2'b11), 32'h200);
      check("model_linear", next_adr(32'h104, 3'b010, 2'b00), 32'h108);
      check("model_const", next_adr(32'h40, 3'b001, 2'b01), 32'h40);

      @(posedge clk); @(posedge clk); #1;
      rst_n  = 1'b1;
      chk_on = 1'b1;

      classic(32'h10, 1'b1, 32'hDEADBEEF, 4'hF);
      classic(32'h10, 1'b0, 32'h0, 4'hF);
      check("classic_rd_dat", dat_o, 32'hDEADBEEF);
      check("classic_rd_ack", {31'b0, ack}, 32'h1);
      check("classic_rd_err", {31'b0, err}, 32'h0);

      classic(32'h10, 1'b1, 32'h000000AA, 4'b0001);
      classic(32'h10, 1'b0, 32'h0, 4'hF);
      check("bytelane_dat", dat_o, 32'hDEADBEAA);
      idle(1);

      burst(32'h100, 8, 1'b1, 3'b010, 2'b00, 32'h11110000, -1);
      burst(32'h100, 8, 1'b0, 3'b010, 2'b00, 32'h0, -1);
      check("incr_last_dat", dat_o, 32'h11110007);
      idle(1);
      check("incr_ack_low_c9", {31'b0, ack}, 32'h0);

      burst(32'h200, 4, 1'b1, 3'b010, 2'b00, 32'h22220000, -1);
      burst(32'h208, 4, 1'b0, 3'b010, 2'b01, 32'h0, -1);
      check("wrap4_last_dat", dat_o, 32'h22220001);

      burst(32'h110, 8, 1'b0, 3'b010, 2'b10, 32'h0, 3);
      check("wrap8_last_dat", dat_o, 32'h11110003);

      burst(32'h40, 3, 1'b1, 3'b001, 2'b00, 32'h33330000, -1);
      classic(32'h40, 1'b0, 32'h0, 4'hF);
      check("const_dat", dat_o, 32'h33330002);

      // Address mismatch on beat 2 drops ack; the held request restarts from idle
      drive(1'b1, 1'b1, 1'b1, 32'h140, 32'hA0A0A0A0, 4'hF, 3'b010, 2'b00);
      model_beat(32'h140, 1'b1, 32'hA0A0A0A0, 4'hF, cyc_n);
      drive(1'b1, 1'b1, 1'b1, 32'h144, 32'hA1A1A1A1, 4'hF, 3'b010, 2'b00);
      model_beat(32'h144, 1'b1, 32'hA1A1A1A1, 4'hF, cyc_n);
      drive(1'b1, 1'b1, 1'b1, 32'h180, 32'hA2A2A2A2, 4'hF, 3'b111, 2'b00);
      drive(1'b1, 1'b1, 1'b1, 32'h180, 32'hA2A2A2A2, 4'hF, 3'b111, 2'b00);
      model_beat(32'h180, 1'b1, 32'hA2A2A2A2, 4'hF, cyc_n);
      drive(1'b1, 1'b1, 1'b1, 32'h180, 32'hA2A2A2A2, 4'hF, 3'b111, 2'b00);
      idle(1);
      classic(32'h180, 1'b0, 32'h0, 4'hF);
      check("mismatch_rd", dat_o, 32'hA2A2A2A2);

      classic(32'h1000, 1'b0, 32'h0, 4'hF);
      check("oor_err", {31'b0, err}, 32'h1);
      check("oor_ack", {31'b0, ack}, 32'h0);
      check("oor_dat_hold", dat_o, 32'hA2A2A2A2);
      classic(32'h1010, 1'b1, 32'hFFFFFFFF, 4'hF);
      classic(32'h10, 1'b0, 32'h0, 4'hF);
      check("oor_no_write", dat_o, 32'hDEADBEAA);
      idle(1);

      // Reset during beat 3 of a write burst
      burst(32'h300, 4, 1'b1, 3'b010, 2'b00, 32'h44440000, -1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b1, 32'h300 + 32'(4 * i), 32'h55550000 + 32'(i), 4'hF, 3'b010, 2'b00);
         model_beat(32'h300 + 32'(4 * i), 1'b1, 32'h55550000 + 32'(i), 4'hF, cyc_n);
      end
      drive(1'b1, 1'b1, 1'b1, 32'h30C, 32'h55550003, 4'hF, 3'b010, 2'b00);
      #2;
      rst_n          = 1'b0;
      e_ack[cyc_n]   = 1'b0;
      e_dchk[cyc_n]  = 1'b0;
      last_dat       = 32'h0;
      #1;
      check("rst_async_ack", {31'b0, ack}, 32'h0);
      check("rst_async_dat", dat_o, 32'h0);
      idle(1);
      rst_n = 1'b1;
      classic(32'h308, 1'b0, 32'h0, 4'hF);
      check("persist_beat2", dat_o, 32'h55550002);
      classic(32'h30C, 1'b0, 32'h0, 4'hF);
      check("no_partial_beat3", dat_o, 32'h44440003);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_burst_mem_slave.md
Name: wb_burst_mem_slave

Overview:
Synthesizable Wishbone B3 slave memory with registered-feedback bursts.
It is the downstream consumer of the team's Wishbone master BFM and is used as the golden target in BFM-driven testbenches.
It supports classic, constant-address and incrementing bursts (linear, wrap-4/8/16), byte-lane writes and out-of-range error signalling.
Memory contents persist across reset, so read-back compare after reset is possible.

Parameters:
aw, 32, address width (byte address)
dw, 32, data width; multiple of 8
MEM_WORDS, 1024, memory depth in dw-wide words; power of two
LFSR_SEED, 8'hA5, seed for wait-state LFSR (only used with WB_MEM_WAIT_EN)

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  reset, asynchronous, active-low
wb_adr_i  in  aw  byte address; word index = wb_adr_i[aw-1:log2(dw/8)]
wb_dat_i  in  dw  write data
wb_sel_i  in  dw/8  byte lane enables
wb_we_i  in  1  1=write
wb_cyc_i  in  1  cycle valid
wb_stb_i  in  1  strobe
wb_cti_i  in  3  000 classic, 001 const, 010 incr, 111 end-of-burst
wb_bte_i  in  2  00 linear, 01 wrap4, 10 wrap8, 11 wrap16
wb_dat_o  out  dw  read data
wb_ack_o  out  1  transfer acknowledge
wb_err_o  out  1  error, address out of range
wb_rty_o  out  1  tied 0

Behaviour:
- Reset (wb_rst_ni=0, async): wb_ack_o=0, wb_err_o=0, wb_dat_o=0, state=IDLE, predicted address=0, LFSR=LFSR_SEED. RAM is not cleared.
- A request is wb_cyc_i & wb_stb_i. Response (ack or err) is registered: it appears one cycle after the request, never combinationally.
- Range: word index >= MEM_WORDS gives wb_err_o instead of wb_ack_o, with the same timing. No write occurs and wb_dat_o holds its value. Error never coexists with ack.
- Writes update only the lanes with wb_sel_i set, on the clock edge where the request is sampled.
- Reads: wb_dat_o is loaded with RAM[word] on the same edge that raises ack, so data is valid while ack=1.
- State machine:
  - IDLE:
    - Request with cti=000 or 111: respond next cycle and go to CLASSIC.
    - Request with cti=001 or 010: respond next cycle, latch predicted next address, go to BURST.
  - CLASSIC:
    - Response is high for exactly one cycle, then the FSM returns to IDLE.
    - A still-held stb is treated as a new request only from IDLE. Back-to-back classic transfers therefore complete every 2 cycles.
  - BURST:
    - Ack stays high every cycle while the request is held, wb_adr_i equals the predicted address, and wb_cti_i is not 111.
    - Each acked beat advances the predicted address: const = same; incr linear = +dw/8; wrap-N = low log2(N)+log2(dw/8) bits increment modulo N beats, upper bits fixed.
    - Sampling cti=111 with a request: perform that final beat, then drop ack and go to IDLE.
    - Address mismatch: drop ack for one cycle, go to IDLE, re-evaluate next cycle (restart as new burst).
    - An error beat in a burst: err for that beat, then go to IDLE.
- wb_cyc_i=0 in any state: ack/err low next cycle, go to IDLE. wb_stb_i low with cyc high in BURST: ack low, stay in BURST (master stall).
- Simultaneous reset assertion mid-burst: outputs low immediately, no partial write on that edge.

Optional Feature:
WB_MEM_WAIT_EN:
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every clock. When lfsr[0]=1, any response due that cycle is withheld and the request stays pending. In BURST the predicted address does not advance on a withheld cycle. Masters must tolerate stalls.
- Undefined: the LFSR is not instantiated; timing is exactly as in Behaviour.

Test Plan:
- Classic write 0xDEADBEEF to 0x10, sel=4'hF, then classic read 0x10 -> ack exactly 1 cycle after each stb, read data 0xDEADBEEF, err=0.
- Byte-lane write 0x000000AA to 0x10 with sel=4'b0001 over 0xDEADBEEF -> read returns 0xDEADBEAA.
- Incr linear burst write of 8 beats from 0x100 (cti 010 ×7 then 111), then same-shaped read -> ack held 8 consecutive cycles, data matches, ack low on cycle 9.
- Wrap-4 burst read starting 0x208, dw=32 -> addresses 0x208, 0x20C, 0x200, 0x204 accepted with continuous ack; data matches prior writes.
- Access to word index MEM_WORDS (0x1000 with defaults) -> wb_err_o pulses 1 cycle, ack stays 0, RAM unchanged.
- Assert wb_rst_ni=0 mid-burst at beat 3 -> ack drops asynchronously. After release, a read of beat-2 address returns its written value (RAM persists).
